// File: rtl/ifc_arb_pkg.sv
// Shared types for ifc_port_arbiter: default DUT widths, FSM states, the
// latched request record and the requester index.
package ifc_arb_pkg;

    localparam int ARB_ADDR_W = 3;
    localparam int ARB_DATA_W = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic                  write;
        logic [ARB_ADDR_W-1:0] addr;
        logic [ARB_DATA_W-1:0] wdata;
    } arb_req_t;

    typedef logic req_idx_t;

    function automatic arb_req_t make_req(input logic                  write,
                                          input logic [ARB_ADDR_W-1:0] addr,
                                          input logic [ARB_DATA_W-1:0] wdata);
        arb_req_t r;
        r.write = write;
        r.addr  = addr;
        r.wdata = wdata;
        return r;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: the requester named by ptr wins a tie,
// a lone requester always wins. Pointer state lives in the parent.
module rr_arb2
    import ifc_arb_pkg::*;
(
    input  logic [1:0] req,
    input  req_idx_t   ptr,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (ptr == 1'b1) begin
            grant[1] = req[1];
            grant[0] = req[0] & ~req[1];
        end else begin
            grant[0] = req[0];
            grant[1] = req[1] & ~req[0];
        end
    end

endmodule

// File: rtl/ifc_port_arbiter.sv
// Shares the single write/read port of the interface DUT between two masters,
// one transaction at a time. Define IFC_ARB_TIMEOUT_EN to abort stalled ISSUEs.
module ifc_port_arbiter
    import ifc_arb_pkg::*;
#(
    parameter int ADDR_W  = ARB_ADDR_W,
    parameter int DATA_W  = ARB_DATA_W,
    parameter int TIMEOUT = 15
) (
    input  logic              CLK,
    input  logic              RST_N,

    input  logic              r0_req_valid,
    input  logic              r0_req_write,
    input  logic [ADDR_W-1:0] r0_req_addr,
    input  logic [DATA_W-1:0] r0_req_wdata,
    output logic              r0_req_ready,
    output logic              r0_resp_valid,
    output logic [DATA_W-1:0] r0_resp_data,
    output logic              r0_resp_err,

    input  logic              r1_req_valid,
    input  logic              r1_req_write,
    input  logic [ADDR_W-1:0] r1_req_addr,
    input  logic [DATA_W-1:0] r1_req_wdata,
    output logic              r1_req_ready,
    output logic              r1_resp_valid,
    output logic [DATA_W-1:0] r1_resp_data,
    output logic              r1_resp_err,

    output logic [ADDR_W-1:0] write_address,
    output logic [DATA_W-1:0] write_data,
    output logic              write_en,
    input  logic              write_rdy,
    output logic [ADDR_W-1:0] read_address,
    output logic              read_en,
    input  logic [DATA_W-1:0] read_data,
    input  logic              read_rdy
);

    arb_state_e        state_q, state_d;
    req_idx_t          ptr_q, ptr_d;
    req_idx_t          owner_q, owner_d;
    arb_req_t          req_q, req_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic [1:0] grant;
    logic       issue, resp, fire, abort;

    rr_arb2 u_rr (
        .req   ({r1_req_valid, r0_req_valid}),
        .ptr   (ptr_q),
        .grant (grant)
    );

    assign issue = (state_q == ISSUE);
    assign resp  = (state_q == RESP);

    assign r0_req_ready = (state_q == IDLE) && grant[0];
    assign r1_req_ready = (state_q == IDLE) && grant[1];

    // DUT enables pass the matching ready straight through, so an enable
    // can never be seen without its ready.
    assign write_en      = issue & req_q.write & write_rdy;
    assign read_en       = issue & ~req_q.write & read_rdy;
    assign fire          = write_en | read_en;
    assign write_address = issue ? req_q.addr  : '0;
    assign read_address  = issue ? req_q.addr  : '0;
    assign write_data    = issue ? req_q.wdata : '0;

    assign r0_resp_valid = resp && (owner_q == 1'b0);
    assign r1_resp_valid = resp && (owner_q == 1'b1);
    assign r0_resp_data  = r0_resp_valid ? rdata_q : '0;
    assign r1_resp_data  = r1_resp_valid ? rdata_q : '0;

`ifdef IFC_ARB_TIMEOUT_EN
    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    // Abort on the TIMEOUT-th ISSUE cycle that did not fire.
    assign abort = issue && !fire && (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (state_q == IDLE) begin
            cnt_d = '0;
        end else if (issue) begin
            if (fire) begin
                err_d = 1'b0;
            end else if (abort) begin
                err_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign r0_resp_err = r0_resp_valid & err_q;
    assign r1_resp_err = r1_resp_valid & err_q;
`else
    assign abort       = 1'b0;
    assign r0_resp_err = 1'b0;
    assign r1_resp_err = 1'b0;

    // TIMEOUT has no effect when the abort path is compiled out.
    if (TIMEOUT < 1) begin : g_timeout_ignored
    end
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        req_d   = req_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (|grant) begin
                    owner_d = grant[1];
                    req_d   = grant[1] ? make_req(r1_req_write, r1_req_addr, r1_req_wdata)
                                       : make_req(r0_req_write, r0_req_addr, r0_req_wdata);
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (fire) begin
                    rdata_d = req_q.write ? '0 : read_data;
                    state_d = RESP;
                end else if (abort) begin
                    rdata_d = '0;
                    state_d = RESP;
                end
            end
            RESP: begin
                ptr_d   = ~owner_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            owner_q <= 1'b0;
            req_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            req_q   <= req_d;
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: tb/tb_ifc_port_arbiter.sv
// Scoreboard bench for ifc_port_arbiter with a behavioural 8x1 DUT memory.
// Define IFC_ARB_TIMEOUT_EN here as for the RTL to exercise the abort path.
module tb_ifc_port_arbiter;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic       r0_req_valid, r0_req_write, r0_req_ready, r0_resp_valid, r0_resp_err;
    logic [2:0] r0_req_addr;
    logic [0:0] r0_req_wdata, r0_resp_data;
    logic       r1_req_valid, r1_req_write, r1_req_ready, r1_resp_valid, r1_resp_err;
    logic [2:0] r1_req_addr;
    logic [0:0] r1_req_wdata, r1_resp_data;
    logic [2:0] write_address, read_address;
    logic [0:0] write_data, read_data;
    logic       write_en, write_rdy, read_en, read_rdy;

    ifc_port_arbiter dut (
        .CLK(CLK), .RST_N(RST_N),
        .r0_req_valid(r0_req_valid), .r0_req_write(r0_req_write), .r0_req_addr(r0_req_addr),
        .r0_req_wdata(r0_req_wdata), .r0_req_ready(r0_req_ready), .r0_resp_valid(r0_resp_valid),
        .r0_resp_data(r0_resp_data), .r0_resp_err(r0_resp_err),
        .r1_req_valid(r1_req_valid), .r1_req_write(r1_req_write), .r1_req_addr(r1_req_addr),
        .r1_req_wdata(r1_req_wdata), .r1_req_ready(r1_req_ready), .r1_resp_valid(r1_resp_valid),
        .r1_resp_data(r1_resp_data), .r1_resp_err(r1_resp_err),
        .write_address(write_address), .write_data(write_data), .write_en(write_en),
        .write_rdy(write_rdy), .read_address(read_address), .read_en(read_en),
        .read_data(read_data), .read_rdy(read_rdy)
    );

    always #5 CLK = ~CLK;

    // Behavioural DUT memory
    logic [7:0] dmem = '0;
    always @(posedge CLK) if (write_en) dmem[write_address] <= write_data[0];
    assign read_data = dmem[read_address];

    typedef struct { int port; logic data; logic err; } exp_t;
    exp_t       sb[$];
    logic [7:0] ref_mem = '0;
    int         total = 0, bad = 0, cyc = 0;
    int         resp_cyc[$];
    int         grant_q[$];
    int         acc_cyc[$];
    int         exp_g[4] = '{0, 1, 0, 1};
    bit         exp_timeout = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic void push_exp(input int p, input logic w, input logic [2:0] a, input logic d);
        exp_t e;
        e.port = p;
        e.err  = 1'b0;
        e.data = 1'b0;
        if (exp_timeout) begin
            e.err = 1'b1;
        end else if (w) begin
            ref_mem[a] = d;
        end else begin
            e.data = ref_mem[a];
        end
        sb.push_back(e);
    endfunction

    always @(posedge CLK) cyc++;

    always @(negedge CLK) begin
        if (RST_N) begin
            check("wen_gated", write_en & ~write_rdy, 0);
            check("ren_gated", read_en & ~read_rdy, 0);
            if (r0_req_valid && r0_req_ready) push_exp(0, r0_req_write, r0_req_addr, r0_req_wdata[0]);
            if (r1_req_valid && r1_req_ready) push_exp(1, r1_req_write, r1_req_addr, r1_req_wdata[0]);
            if (r0_resp_valid || r1_resp_valid) begin
                exp_t e;
                resp_cyc.push_back(cyc);
                check("resp_onehot", r0_resp_valid & r1_resp_valid, 0);
                check("sb_has_entry", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("resp_port", r1_resp_valid, e.port);
                    check("resp_data", r1_resp_valid ? r1_resp_data : r0_resp_data, e.data);
                    check("resp_err", r1_resp_valid ? r1_resp_err : r0_resp_err, e.err);
                end
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic drive(input int p, input logic w, input logic [2:0] a, input logic d);
        if (p == 0) begin
            r0_req_valid = 1'b1; r0_req_write = w; r0_req_addr = a; r0_req_wdata = d;
        end else begin
            r1_req_valid = 1'b1; r1_req_write = w; r1_req_addr = a; r1_req_wdata = d;
        end
    endtask

    task automatic do_txn(input int p, input logic w, input logic [2:0] a, input logic d);
        bit got = 1'b0;
        drive(p, w, a, d);
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge CLK);
            got = (p == 0) ? r0_req_ready : r1_req_ready;
            step();
        end
        check("txn_accept", got, 1);
        if (p == 0) r0_req_valid = 1'b0; else r1_req_valid = 1'b0;
    endtask

    initial begin
        int  n;
        bit  a0, a1, got;
        int  k0, k1, nacc;
        RST_N = 1'b0;
        r0_req_valid = 0; r0_req_write = 0; r0_req_addr = 0; r0_req_wdata = 0;
        r1_req_valid = 0; r1_req_write = 0; r1_req_addr = 0; r1_req_wdata = 0;
        write_rdy = 1'b1; read_rdy = 1'b1;

        @(negedge CLK);
        check("rst_outs", {write_en, read_en, write_address, read_address, write_data,
                           r0_resp_valid, r1_resp_valid, r0_resp_data, r1_resp_data,
                           r0_resp_err, r1_resp_err, r0_req_ready, r1_req_ready}, 0);
        step();
        RST_N = 1'b1;
        idle(1);

        // single write from r0
        drive(0, 1'b1, 3'd5, 1'b1);
        @(negedge CLK);
        check("t1_ready", r0_req_ready, 1);
        check("t1_r1_ready", r1_req_ready, 0);
        step();
        r0_req_valid = 1'b0;
        @(negedge CLK);
        check("t1_wen", write_en, 1);
        check("t1_waddr", write_address, 5);
        check("t1_wdata", write_data, 1);
        check("t1_r0_busy", r0_req_ready, 0);
        step();
        @(negedge CLK);
        check("t1_resp", r0_resp_valid, 1);
        check("t1_rdata", r0_resp_data, 0);
        check("t1_err", r0_resp_err, 0);
        step();
        @(negedge CLK);
        check("t1_resp_pulse", r0_resp_valid, 0);
        step();

        // r1 read with read_rdy stalled 4 cycles
        read_rdy = 1'b0;
        drive(1, 1'b0, 3'd5, 1'b0);
        @(negedge CLK);
        check("t2_ready", r1_req_ready, 1);
        step();
        r1_req_valid = 1'b0;
        repeat (4) begin
            @(negedge CLK);
            check("t2_ren_wait", read_en, 0);
            check("t2_no_resp", r1_resp_valid, 0);
            step();
        end
        read_rdy = 1'b1;
        @(negedge CLK);
        check("t2_ren", read_en, 1);
        check("t2_raddr", read_address, 5);
        step();
        @(negedge CLK);
        check("t2_resp", r1_resp_valid, 1);
        check("t2_rdata", r1_resp_data, 1);
        step();

        // both requesters continuously valid from reset
        RST_N = 1'b0;
        step();
        RST_N = 1'b1;
        resp_cyc.delete();
        k0 = 0; k1 = 0; nacc = 0;
        drive(0, 1'b1, 3'd1, 1'b1);
        drive(1, 1'b0, 3'd1, 1'b0);
        for (int c = 0; c < 40 && nacc < 4; c++) begin
            @(negedge CLK);
            check("t3_ready_excl", r0_req_ready & r1_req_ready, 0);
            a0 = r0_req_valid & r0_req_ready;
            a1 = r1_req_valid & r1_req_ready;
            if (a0) begin grant_q.push_back(0); acc_cyc.push_back(c); end
            if (a1) begin grant_q.push_back(1); acc_cyc.push_back(c); end
            step();
            if (a0) begin
                k0++;
                if (k0 < 2) r0_req_wdata = 1'b0; else r0_req_valid = 1'b0;
            end
            if (a1) begin
                k1++;
                if (k1 >= 2) r1_req_valid = 1'b0;
            end
            nacc += int'(a0) + int'(a1);
        end
        idle(4);
        check("t3_n_acc", grant_q.size(), 4);
        for (int i = 0; i < grant_q.size() && i < 4; i++) check("t3_grant", grant_q[i], exp_g[i]);
        for (int i = 1; i < acc_cyc.size(); i++) check("t3_acc_gap", acc_cyc[i] - acc_cyc[i-1], 3);
        check("t3_n_resp", resp_cyc.size(), 4);
        for (int i = 1; i < resp_cyc.size(); i++) check("t3_resp_gap", resp_cyc[i] - resp_cyc[i-1], 3);

        // reset in the middle of an r1 read
        do_txn(0, 1'b1, 3'd3, 1'b1);
        idle(3);
        read_rdy = 1'b0;
        do_txn(1, 1'b0, 3'd5, 1'b0);
        #2;
        read_rdy = 1'b1;
        #1;
        check("t4_ren_before", read_en, 1);
        RST_N = 1'b0;
        #1;
        check("t4_outs_zero", {write_en, read_en, write_address, read_address, write_data,
                               r0_resp_valid, r1_resp_valid}, 0);
        sb.delete();
        step();
        RST_N = 1'b1;
        repeat (4) begin
            @(negedge CLK);
            check("t4_no_resp", r0_resp_valid | r1_resp_valid, 0);
            step();
        end
        drive(0, 1'b1, 3'd6, 1'b1);
        drive(1, 1'b1, 3'd7, 1'b1);
        @(negedge CLK);
        check("t4_r0_first", r0_req_ready, 1);
        check("t4_r1_wait", r1_req_ready, 0);
        step();
        r0_req_valid = 1'b0;
        do_txn(1, 1'b1, 3'd7, 1'b1);
        idle(3);

        // write held off by write_rdy low
        write_rdy = 1'b0;
`ifdef IFC_ARB_TIMEOUT_EN
        exp_timeout = 1'b1;
`endif
        drive(0, 1'b1, 3'd4, 1'b1);
        @(negedge CLK);
        check("t5_accept", r0_req_ready, 1);
        step();
        r0_req_valid = 1'b0;
        exp_timeout = 1'b0;
`ifdef IFC_ARB_TIMEOUT_EN
        n = 0; got = 1'b0;
        for (int i = 1; i <= 40 && !got; i++) begin
            @(negedge CLK);
            check("t5_wen_blocked", write_en, 0);
            if (r0_resp_valid) begin got = 1'b1; n = i; end
            step();
        end
        check("t5_timeout_lat", n, 16);
`else
        repeat (20) begin
            @(negedge CLK);
            check("t5_hold", r0_resp_valid, 0);
            check("t5_wen_blocked", write_en, 0);
            step();
        end
        write_rdy = 1'b1;
        @(negedge CLK);
        check("t5_wen", write_en, 1);
        step();
        @(negedge CLK);
        check("t5_resp", r0_resp_valid, 1);
        step();
`endif
        write_rdy = 1'b1;
        idle(3);
        check("sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
